// File: rtl/mem_trace_pkg.sv
// Shared types and entry-layout helpers for the MEM-stage trace buffer.
package mem_trace_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } trace_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } trace_op_t;

  // Entry layout, LSB first: data, addr, ts, op.
  localparam int unsigned DATA_LSB = 0;

  function automatic int unsigned addr_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned ts_lsb(input int unsigned data_w, input int unsigned addr_w);
    return data_w + addr_w;
  endfunction

  function automatic int unsigned op_bit(input int unsigned data_w, input int unsigned addr_w,
                                         input int unsigned ts_w);
    return data_w + addr_w + ts_w;
  endfunction

endpackage

// File: rtl/mem_trace_ram.sv
// Trace storage: register array, one synchronous write port, one asynchronous read port.
module mem_trace_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned W     = 81
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Store one entry per cycle at the write pointer.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_trace_buf.sv
// Circular trace buffer for MEM-stage loads/stores with address trigger,
// post-trigger window, freeze, and first-word-fall-through drain port.
module mem_trace_buf
  import mem_trace_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TS_W      = 16,
  parameter int unsigned POST_TRIG = 16
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            en_MEM,
  input  logic                            en_WB,
  input  logic [ADDR_W-1:0]               i_memAddr,
  input  logic [DATA_W-1:0]               i_writeData,
  input  logic [1:0]                      i_ctrlMEM,
  input  logic [DATA_W-1:0]               i_readData,
  input  logic                            i_arm,
  input  logic                            i_disarm,
  input  logic [ADDR_W-1:0]               i_trigAddr,
  input  logic [ADDR_W-1:0]               i_trigMask,
  input  logic [1:0]                      i_trigOps,
  input  logic                            i_rdReady,
  output logic                            o_rdValid,
  output logic [TS_W+ADDR_W+DATA_W:0]     o_rdEntry,
  output logic [$clog2(DEPTH):0]          o_level,
  output logic [1:0]                      o_state,
  output logic                            o_wrapped,
  output logic [7:0]                      o_dropCount
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned ENT_W   = 1 + TS_W + ADDR_W + DATA_W;
  localparam int unsigned A_LSB   = addr_lsb(DATA_W);
  localparam int unsigned T_LSB   = ts_lsb(DATA_W, ADDR_W);
  localparam int unsigned OP_POS  = op_bit(DATA_W, ADDR_W, TS_W);

  trace_state_t      state_q, state_d;
  logic [TS_W-1:0]   ts_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d, post_cnt_q, post_cnt_d;
  logic              wrapped_q, wrapped_d;
  logic [7:0]        drop_q, drop_d;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              hold_v_q, hold_v_d;
  logic [ENT_W-1:0]  hold_q, hold_d;

  logic              arm, capturing, rd_ev, wr_ev, we, drop, trig_hit, rd_valid, pop;
  logic [ENT_W-1:0]  rd_entry, wr_entry, wentry, ram_rdata;

  mem_trace_ram #(
    .DEPTH (DEPTH),
    .AW    (PTR_W),
    .W     (ENT_W)
  ) u_ram (
    .clk_i   (i_clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wentry),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Event decode and single-write-port arbitration.
  // Candidates in age order: holding reg, READ completion, WRITE. The first is
  // written, the second parks in the holding reg (freed by this cycle's write),
  // and a third (always a WRITE) is dropped.
  always_comb begin
    arm       = i_arm & ~i_disarm;
    capturing = (state_q == ARMED) || (state_q == POST);
    rd_ev     = en_WB & pend_v_q;
    wr_ev     = en_MEM & i_ctrlMEM[0];

    rd_entry                      = '0;
    rd_entry[OP_POS]              = OP_RD;
    rd_entry[T_LSB +: TS_W]       = ts_q;
    rd_entry[A_LSB +: ADDR_W]     = pend_addr_q;
    rd_entry[DATA_LSB +: DATA_W]  = i_readData;

    wr_entry                      = '0;
    wr_entry[OP_POS]              = OP_WR;
    wr_entry[T_LSB +: TS_W]       = ts_q;
    wr_entry[A_LSB +: ADDR_W]     = i_memAddr;
    wr_entry[DATA_LSB +: DATA_W]  = i_writeData;

    we       = 1'b0;
    wentry   = '0;
    drop     = 1'b0;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;

    if (capturing && !arm) begin
      if (hold_v_q) begin
        we       = 1'b1;
        wentry   = hold_q;
        hold_v_d = 1'b0;
        if (rd_ev) begin
          hold_d   = rd_entry;
          hold_v_d = 1'b1;
          drop     = wr_ev;
        end else if (wr_ev) begin
          hold_d   = wr_entry;
          hold_v_d = 1'b1;
        end
      end else if (rd_ev) begin
        we     = 1'b1;
        wentry = rd_entry;
        if (wr_ev) begin
          hold_d   = wr_entry;
          hold_v_d = 1'b1;
        end
      end else if (wr_ev) begin
        we     = 1'b1;
        wentry = wr_entry;
      end
    end

    trig_hit = we &&
               (((wentry[A_LSB +: ADDR_W] ^ i_trigAddr) & i_trigMask) == '0) &&
               (wentry[OP_POS] ? i_trigOps[0] : i_trigOps[1]);

    rd_valid = (state_q == FROZEN) && (level_q != '0);
    pop      = rd_valid & i_rdReady;
  end

  // Pointer, level, pending-read and status next-state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    wrapped_d   = wrapped_q;
    drop_d      = drop_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;

    if (rd_ev) pend_v_d = 1'b0;
    if (en_MEM && i_ctrlMEM[1]) begin
      pend_v_d    = 1'b1;
      pend_addr_d = i_memAddr;
    end

    if (we) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (level_q == LVL_W'(DEPTH)) begin
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        wrapped_d = 1'b1;
      end else begin
        level_d = level_q + LVL_W'(1);
      end
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d  = level_q - LVL_W'(1);
    end

    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    if (arm) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      wrapped_d = 1'b0;
      drop_d    = '0;
      pend_v_d  = 1'b0;
    end
  end

  // Trace FSM next-state; disarm beats arm.
  always_comb begin
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    unique case (state_q)
      ARMED: begin
        if (trig_hit) begin
          state_d    = (POST_TRIG == 0) ? FROZEN : POST;
          post_cnt_d = '0;
        end
      end
      POST: begin
        if (we) begin
          if (post_cnt_q == LVL_W'(POST_TRIG - 1)) state_d = FROZEN;
          else post_cnt_d = post_cnt_q + LVL_W'(1);
        end
      end
      default: ;
    endcase
    if (arm)      state_d = ARMED;
    if (i_disarm) state_d = IDLE;
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Datapath registers: timestamp, pointers, pending read, holding entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ts_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      post_cnt_q  <= '0;
      wrapped_q   <= 1'b0;
      drop_q      <= '0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      hold_v_q    <= 1'b0;
      hold_q      <= '0;
    end else begin
      ts_q        <= ts_q + TS_W'(1);
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      post_cnt_q  <= post_cnt_d;
      wrapped_q   <= wrapped_d;
      drop_q      <= drop_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      hold_v_q    <= arm ? 1'b0 : hold_v_d;
      hold_q      <= hold_d;
    end
  end

  assign o_rdValid   = rd_valid;
  assign o_rdEntry   = rd_valid ? ram_rdata : '0;
  assign o_level     = level_q;
  assign o_state     = state_q;
  assign o_wrapped   = wrapped_q;
  assign o_dropCount = drop_q;

endmodule

// File: tb/tb_mem_trace_buf.sv
// Directed bench for mem_trace_buf with hand-derived expected entries.
module tb_mem_trace_buf;

  logic        clk = 1'b0;
  logic        i_reset, en_MEM, en_WB, i_arm, i_disarm, i_rdReady;
  logic [31:0] i_memAddr, i_writeData, i_readData, i_trigAddr, i_trigMask;
  logic [1:0]  i_ctrlMEM, i_trigOps;
  logic        o_rdValid, o_wrapped;
  logic [80:0] o_rdEntry;
  logic [6:0]  o_level;
  logic [1:0]  o_state;
  logic [7:0]  o_dropCount;

  logic [15:0] tb_ts = '0;
  logic [80:0] expq[$];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  mem_trace_buf #(
    .DEPTH     (64),
    .ADDR_W    (32),
    .DATA_W    (32),
    .TS_W      (16),
    .POST_TRIG (1)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .en_MEM      (en_MEM),
    .en_WB       (en_WB),
    .i_memAddr   (i_memAddr),
    .i_writeData (i_writeData),
    .i_ctrlMEM   (i_ctrlMEM),
    .i_readData  (i_readData),
    .i_arm       (i_arm),
    .i_disarm    (i_disarm),
    .i_trigAddr  (i_trigAddr),
    .i_trigMask  (i_trigMask),
    .i_trigOps   (i_trigOps),
    .i_rdReady   (i_rdReady),
    .o_rdValid   (o_rdValid),
    .o_rdEntry   (o_rdEntry),
    .o_level     (o_level),
    .o_state     (o_state),
    .o_wrapped   (o_wrapped),
    .o_dropCount (o_dropCount)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: mirrors the free-running timestamp definition.
  always @(posedge clk) tb_ts <= i_reset ? 16'd0 : tb_ts + 16'd1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input bit capt);
    en_MEM = 1'b1; i_ctrlMEM = 2'b01; i_memAddr = a; i_writeData = d;
    if (capt) expq.push_back({1'b1, tb_ts, a, d});
    tick();
    en_MEM = 1'b0; i_ctrlMEM = 2'b00;
  endtask

  task automatic arm_trig(input logic [31:0] ta, input logic [1:0] ops);
    i_trigAddr = ta; i_trigMask = 32'hFFFF_FFFF; i_trigOps = ops;
    i_arm = 1'b1; tick(); i_arm = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    while (expq.size() != 0) begin
      chk("rd_valid", 128'(o_rdValid), 128'(1));
      chk("rd_entry", 128'(o_rdEntry), 128'(expq[0]));
      if (toggle) begin
        i_rdReady = 1'b0; tick();
        chk("rd_stall", 128'(o_rdEntry), 128'(expq[0]));
      end
      i_rdReady = 1'b1; tick(); i_rdReady = 1'b0;
      void'(expq.pop_front());
    end
    chk("drain_valid0", 128'(o_rdValid), 128'(0));
    chk("drain_level0", 128'(o_level), 128'(0));
    chk("drain_frozen", 128'(o_state), 128'(3));
  endtask

  initial begin
    i_reset = 1'b1; en_MEM = 0; en_WB = 0; i_arm = 0; i_disarm = 0; i_rdReady = 0;
    i_memAddr = '0; i_writeData = '0; i_readData = '0; i_ctrlMEM = '0;
    i_trigAddr = '0; i_trigMask = '0; i_trigOps = '0;

    // 1. reset values, then IDLE ignores traffic
    tick(); tick();
    chk("rst_state",   128'(o_state),     128'(0));
    chk("rst_level",   128'(o_level),     128'(0));
    chk("rst_valid",   128'(o_rdValid),   128'(0));
    chk("rst_entry",   128'(o_rdEntry),   128'(0));
    chk("rst_wrapped", 128'(o_wrapped),   128'(0));
    chk("rst_drop",    128'(o_dropCount), 128'(0));
    i_reset = 1'b0;
    do_wr(32'h50, 32'h5, 1'b0);
    tick();
    chk("idle_level", 128'(o_level), 128'(0));

    // 2. three writes, trigger on 0x104, freeze after 0x108
    arm_trig(32'h104, 2'b01);
    chk("t2_armed", 128'(o_state), 128'(1));
    do_wr(32'h100, 32'hA0, 1'b1);
    do_wr(32'h104, 32'hA4, 1'b1);
    chk("t2_post", 128'(o_state), 128'(2));
    do_wr(32'h108, 32'hA8, 1'b1);
    chk("t2_frozen", 128'(o_state), 128'(3));
    chk("t2_level",  128'(o_level), 128'(3));
    drain(1'b0);

    // 3. stray WB is ignored; two-phase read triggers, one write closes window
    arm_trig(32'h200, 2'b10);
    en_WB = 1'b1; i_readData = 32'h1234; tick(); en_WB = 1'b0;
    tick();
    chk("t3_nopend", 128'(o_level), 128'(0));
    en_MEM = 1'b1; i_ctrlMEM = 2'b10; i_memAddr = 32'h200; tick();
    en_MEM = 1'b0; i_ctrlMEM = 2'b00; tick();
    en_WB = 1'b1; i_readData = 32'hCAFE_F00D;
    expq.push_back({1'b0, tb_ts, 32'h200, 32'hCAFE_F00D});
    tick(); en_WB = 1'b0;
    chk("t3_post", 128'(o_state), 128'(2));
    do_wr(32'h300, 32'h33, 1'b1);
    chk("t3_frozen", 128'(o_state), 128'(3));
    drain(1'b0);

    // 4. 70 writes into 64 entries; trigger at 0x110, freeze after 0x114
    arm_trig(32'h110, 2'b01);
    chk("t4_wrapped0", 128'(o_wrapped), 128'(0));
    for (int unsigned i = 0; i < 70; i++) do_wr(32'(i * 4), 32'(i) ^ 32'h5A5A_0000, 1'b1);
    for (int unsigned i = 0; i < 6; i++) void'(expq.pop_front());
    chk("t4_frozen",  128'(o_state),          128'(3));
    chk("t4_wrapped", 128'(o_wrapped),        128'(1));
    chk("t4_level",   128'(o_level),          128'(64));
    chk("t4_first",   128'(o_rdEntry[63:32]), 128'(32'h18));
    // 6a. ready toggling through the drain
    drain(1'b1);

    // 5. back-to-back READ completion + WRITE
    arm_trig(32'h700, 2'b01);
    en_MEM = 1'b1; i_ctrlMEM = 2'b10; i_memAddr = 32'h400; tick();
    en_WB = 1'b1; i_readData = 32'hD1;
    i_ctrlMEM = 2'b11; i_memAddr = 32'h500; i_writeData = 32'hE1;
    expq.push_back({1'b0, tb_ts, 32'h400, 32'hD1});
    expq.push_back({1'b1, tb_ts, 32'h500, 32'hE1});
    tick();
    i_readData = 32'hD2; i_ctrlMEM = 2'b01; i_memAddr = 32'h600; i_writeData = 32'hE2;
    expq.push_back({1'b0, tb_ts, 32'h500, 32'hD2});
    tick();
    en_MEM = 1'b0; en_WB = 1'b0; i_ctrlMEM = 2'b00;
    chk("t5_level2", 128'(o_level),     128'(2));
    chk("t5_drop",   128'(o_dropCount), 128'(1));
    tick();
    chk("t5_level3", 128'(o_level),     128'(3));
    do_wr(32'h700, 32'h77, 1'b1);
    do_wr(32'h704, 32'h78, 1'b1);
    chk("t5_frozen", 128'(o_state), 128'(3));
    drain(1'b0);

    // 6b. arm+disarm together goes IDLE with contents kept; reset discards
    arm_trig(32'hFFF0, 2'b01);
    do_wr(32'h10, 32'h1, 1'b0);
    do_wr(32'h14, 32'h2, 1'b0);
    chk("t6_level2", 128'(o_level), 128'(2));
    i_arm = 1'b1; i_disarm = 1'b1; tick(); i_arm = 1'b0; i_disarm = 1'b0;
    chk("t6_idle",      128'(o_state),   128'(0));
    chk("t6_kept",      128'(o_level),   128'(2));
    chk("t6_novalid",   128'(o_rdValid), 128'(0));
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    chk("t6_rst_level", 128'(o_level), 128'(0));
    chk("t6_rst_state", 128'(o_state), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
